piso_fifo_flow: RTL and testbench
=================================

PISO_FIFO_FLOW -- requirements
Module: piso_fifo_flow

Interface
REQ-001 The block SHALL have parameter width_p, default 32: serial word width in bits.
REQ-002 The block SHALL have parameter els_p, default 4: number of serial words per parallel input.
REQ-003 The block SHALL have parameter fifo_els_p, default 8: output FIFO depth in serial words.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port valid_i, input, 1 bit: the parallel input word is valid.
REQ-007 The block SHALL have port data_i, input, els_p*width_p bits: the parallel input word.
REQ-008 The block SHALL have port ready_and_o, output, 1 bit: the serializer can accept a parallel word.
REQ-009 The block SHALL have port valid_o, output, 1 bit: FIFO head valid.
REQ-010 The block SHALL have port data_o, output, width_p bits: FIFO head data.
REQ-011 The block SHALL have port yumi_i, input, 1 bit: consumer takes the head; it is legal only when valid_o=1.
REQ-012 The block SHALL have port count_o, output, clog2(fifo_els_p+1) bits: free FIFO slots.

Function
REQ-013 The parallel word SHALL be accepted on the cycle where valid_i & ready_and_o is high.
REQ-014 ready_and_o SHALL be 1 only while the serializer holds no words; it SHALL NOT depend combinationally on yumi_i or FIFO state.
REQ-015 An accepted word SHALL be emitted into the FIFO as els_p serial words, slice 0 (data_i[width_p-1:0]) first, ascending.
REQ-016 Each slice SHALL be written only on cycles where the FIFO is not full; when the FIFO is full the serializer SHALL stall and hold the current slice.
REQ-017 After the last slice is written, ready_and_o SHALL rise on the next cycle; the accept-to-accept period is therefore at least els_p+1 cycles.
REQ-018 For els_p=1, the serializer SHALL still register the word, with one write per accept.
REQ-019 The FIFO SHALL be first-in first-out; valid_o=1 iff occupancy>0, and data_o SHALL be the oldest entry.
REQ-020 A FIFO write SHALL be visible at valid_o no earlier than the next cycle; there SHALL be no bypass path.
REQ-021 The FIFO SHALL assert its internal ready iff occupancy<fifo_els_p; a simultaneous read while full SHALL NOT enable a write that cycle.
REQ-022 A simultaneous write and read SHALL leave occupancy unchanged, with pointers wrapping modulo fifo_els_p.
REQ-023 count_o SHALL equal fifo_els_p minus occupancy, registered. It SHALL decrement on a write, increment on yumi_i, and stay unchanged when both occur in the same cycle.
REQ-024 count_o SHALL never leave the range 0..fifo_els_p.

Reset
REQ-025 While reset_i=1 at a clock edge, the block SHALL clear the serializer and FIFO.
REQ-026 After that reset edge, ready_and_o SHALL be 1, valid_o SHALL be 0 and count_o SHALL equal fifo_els_p.
REQ-027 data_o SHALL be don't-care during reset.
REQ-028 A reset mid-serialization SHALL discard all pending slices and stored words.
REQ-029 Inputs SHALL be ignored during the reset cycle.

Configuration
REQ-030 When the macro PISO_FIFO_FLOW_ASSERT_EN is defined, simulation checks SHALL raise an error on:
- yumi_i=1 while valid_o=0;
- fifo_els_p<1;
- els_p<1;
- count_o plus occupancy not equal to fifo_els_p.
REQ-031 When PISO_FIFO_FLOW_ASSERT_EN is undefined, the checks SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-032 Reset, then idle -> ready_and_o=1, valid_o=0, count_o=8.
REQ-033 One accept of data_i=0x44444444_33333333_22222222_11111111, with yumi_i=0 -> FIFO receives 0x11111111, 0x22222222, 0x33333333, 0x44444444 in order; count_o steps 8,7,6,5,4; ready_and_o returns to 1.
REQ-034 Three accepts with yumi_i=0 -> the FIFO fills after 8 words and count_o=0; the third word stalls with ready_and_o=0; one yumi -> count_o=1, then the next slice is written and count_o=0.
REQ-035 FIFO holding 3 words, with a write and yumi_i in the same cycle -> count_o stays 5 and order is preserved across pointer wrap after 20 continuous words.
REQ-036 reset_i asserted after 2 of 4 slices are written -> the next cycle shows valid_o=0, count_o=8, ready_and_o=1, with no stale words emitted.
REQ-037 Random valid_i and yumi_i over 10000 cycles -> the output stream equals the serialized input stream, and count_o+occupancy=8 every cycle.

Source files
------------

// File: rtl/piso_fifo_flow.sv
// piso_fifo_flow: parallel-in serial-out serializer feeding an output FIFO.
// Takes one els_p*width_p word per handshake and drains it slice 0 first.
//
// Parameters:
//   width_p    - serial word width in bits
//   els_p      - serial words per parallel input word
//   fifo_els_p - output FIFO depth in serial words
// Ports:
//   clk_i       in   clock
//   reset_i     in   synchronous active-high reset
//   valid_i     in   parallel word valid
//   data_i      in   parallel word, slice 0 in the low bits
//   ready_and_o out  serializer is empty and can take a word
//   valid_o     out  FIFO head valid
//   data_o      out  FIFO head data
//   yumi_i      in   consumer takes the head (only while valid_o)
//   count_o     out  free FIFO slots, registered
// Optional: define PISO_FIFO_FLOW_ASSERT_EN to enable simulation checks.

module piso_fifo_flow #(
    parameter int width_p    = 32,
    parameter int els_p      = 4,
    parameter int fifo_els_p = 8
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             valid_i,
    input  logic [els_p*width_p-1:0]         data_i,
    output logic                             ready_and_o,
    output logic                             valid_o,
    output logic [width_p-1:0]               data_o,
    input  logic                             yumi_i,
    output logic [$clog2(fifo_els_p+1)-1:0]  count_o
);

    localparam int cnt_w = $clog2(fifo_els_p + 1);
    localparam int ptr_w = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int idx_w = (els_p > 1) ? $clog2(els_p) : 1;

    localparam logic [idx_w-1:0] idx_last = idx_w'(els_p - 1);
    localparam logic [ptr_w-1:0] ptr_last = ptr_w'(fifo_els_p - 1);
    localparam logic [cnt_w-1:0] cnt_full = cnt_w'(fifo_els_p);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e state_r, state_n;

    logic [els_p*width_p-1:0] word_r;
    logic [idx_w-1:0]         idx_r, idx_n;
    logic                     load;
    logic                     wr;
    logic                     rd;
    logic                     fifo_ready;
    logic [width_p-1:0]       slice;

    logic [width_p-1:0] mem_r [fifo_els_p];
    logic [ptr_w-1:0]   wptr_r, rptr_r;
    logic [cnt_w-1:0]   occ_r;
    logic [cnt_w-1:0]   count_r;

    // ---------------- serializer ----------------

    // Ready comes only from the serializer state, never from the FIFO.
    assign ready_and_o = (state_r == S_IDLE);
    assign slice       = word_r[idx_r*width_p +: width_p];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= S_IDLE;
            idx_r   <= '0;
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
        end
    end

    // The word register needs no reset; it is only read while busy.
    always_ff @(posedge clk_i) begin
        if (load) begin
            word_r <= data_i;
        end
    end

    always_comb begin
        state_n = state_r;
        idx_n   = idx_r;
        load    = 1'b0;
        wr      = 1'b0;
        unique case (state_r)
            S_IDLE: begin
                if (valid_i) begin
                    load    = 1'b1;
                    idx_n   = '0;
                    state_n = S_BUSY;
                end
            end
            S_BUSY: begin
                // Hold the current slice while the FIFO is full.
                if (fifo_ready) begin
                    wr = 1'b1;
                    if (idx_r == idx_last) begin
                        idx_n   = '0;
                        state_n = S_IDLE;
                    end else begin
                        idx_n = idx_r + 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // ---------------- output FIFO ----------------

    // Full check uses occupancy only, so a read while full does not
    // open a slot for a write in the same cycle.
    assign fifo_ready = (occ_r < cnt_full);
    assign valid_o    = (occ_r != '0);
    assign data_o     = mem_r[rptr_r];
    assign rd         = yumi_i & valid_o;
    assign count_o    = count_r;

    always_ff @(posedge clk_i) begin
        if (wr) begin
            mem_r[wptr_r] <= slice;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            occ_r   <= '0;
            count_r <= cnt_full;
        end else begin
            if (wr) begin
                wptr_r <= (wptr_r == ptr_last) ? '0 : wptr_r + 1'b1;
            end
            if (rd) begin
                rptr_r <= (rptr_r == ptr_last) ? '0 : rptr_r + 1'b1;
            end
            unique case ({wr, rd})
                2'b10: begin
                    occ_r   <= occ_r + 1'b1;
                    count_r <= count_r - 1'b1;
                end
                2'b01: begin
                    occ_r   <= occ_r - 1'b1;
                    count_r <= count_r + 1'b1;
                end
                default: begin
                    occ_r   <= occ_r;
                    count_r <= count_r;
                end
            endcase
        end
    end

`ifdef PISO_FIFO_FLOW_ASSERT_EN
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !valid_o))
                else $error("yumi_i asserted while valid_o=0");
            assert (fifo_els_p >= 1)
                else $error("fifo_els_p must be at least 1");
            assert (els_p >= 1)
                else $error("els_p must be at least 1");
            assert ((int'(count_r) + int'(occ_r)) == fifo_els_p)
                else $error("count_o plus occupancy != fifo_els_p");
        end
    end
`endif

endmodule

// File: tb/tb_piso_fifo_flow.sv
// tb_piso_fifo_flow: directed vector table plus multi-cycle sequences
// checked against a small cycle model of serializer and FIFO.

module tb_piso_fifo_flow;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         valid_i;
    logic [127:0] data_i;
    logic         ready_and_o;
    logic         valid_o;
    logic [31:0]  data_o;
    logic         yumi_i;
    logic [3:0]   count_o;

    int total = 0;
    int bad   = 0;

    // model state
    int          m_occ = 0;
    int          m_ser = 0;
    logic [31:0] m_q[$];

    piso_fifo_flow #(
        .width_p    (32),
        .els_p      (4),
        .fifo_els_p (8)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .ready_and_o (ready_and_o),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .yumi_i      (yumi_i),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         chk;
        logic         rst;
        logic         v;
        logic         y;
        logic [127:0] d;
        logic         e_rdy;
        logic         e_vld;
        logic [31:0]  e_dat;
        logic [3:0]   e_cnt;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, advance model at posedge,
    // compare at the following negedge.
    task automatic step(input logic r, input logic v,
                        input logic [127:0] d, input logic y);
        bit acc, w, rd_m;
        reset_i = r;
        valid_i = v;
        data_i  = d;
        yumi_i  = y;
        acc  = v && (m_ser == 0);
        w    = (m_ser > 0) && (m_occ < 8);
        rd_m = y && (m_occ > 0);
        @(posedge clk);
        if (r) begin
            m_occ = 0;
            m_ser = 0;
            m_q.delete();
        end else begin
            if (w) begin
                m_occ++;
                m_ser--;
            end
            if (rd_m) begin
                m_occ--;
                void'(m_q.pop_front());
            end
            if (acc) begin
                m_ser = 4;
                for (int i = 0; i < 4; i++)
                    m_q.push_back(d[i*32 +: 32]);
            end
        end
        @(negedge clk);
        chk("m_ready", {31'd0, ready_and_o}, {31'd0, m_ser == 0});
        chk("m_valid", {31'd0, valid_o}, {31'd0, m_occ > 0});
        chk("m_count", {28'd0, count_o}, 32'(8 - m_occ));
        if (m_occ > 0)
            chk("m_data", data_o, m_q[0]);
    endtask

    localparam logic [127:0] D1 =
        128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] D2 =
        128'hD0D0D0D0_C0C0C0C0_B0B0B0B0_A0A0A0A0;

    initial begin
        logic [127:0] d;
        int           nacc;
        bit           started;
        bit           first;
        bit           v;
        bit           y;

        reset_i = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        yumi_i  = 1'b0;

        //          chk rst v  y  d    rdy vld dat           cnt
        vt[0]  = '{0, 1, 0, 0, '0, 0, 0, 32'h0,        4'd0};
        vt[1]  = '{1, 0, 1, 0, D1, 1, 0, 32'h0,        4'd8};
        vt[2]  = '{1, 0, 0, 0, '0, 0, 0, 32'h0,        4'd8};
        vt[3]  = '{1, 0, 0, 0, '0, 0, 1, 32'h11111111, 4'd7};
        vt[4]  = '{1, 0, 0, 0, '0, 0, 1, 32'h11111111, 4'd6};
        vt[5]  = '{1, 0, 0, 0, '0, 0, 1, 32'h11111111, 4'd5};
        vt[6]  = '{1, 0, 0, 1, '0, 1, 1, 32'h11111111, 4'd4};
        vt[7]  = '{1, 0, 0, 1, '0, 1, 1, 32'h22222222, 4'd5};
        vt[8]  = '{1, 0, 0, 1, '0, 1, 1, 32'h33333333, 4'd6};
        vt[9]  = '{1, 0, 0, 1, '0, 1, 1, 32'h44444444, 4'd7};
        vt[10] = '{1, 0, 1, 0, D2, 1, 0, 32'h0,        4'd8};
        vt[11] = '{1, 0, 0, 0, '0, 0, 0, 32'h0,        4'd8};
        vt[12] = '{1, 0, 0, 0, '0, 0, 1, 32'hA0A0A0A0, 4'd7};
        vt[13] = '{1, 1, 1, 0, D1, 0, 1, 32'hA0A0A0A0, 4'd6};
        vt[14] = '{1, 0, 0, 0, '0, 1, 0, 32'h0,        4'd8};
        vt[15] = '{1, 0, 0, 0, '0, 1, 0, 32'h0,        4'd8};

        @(negedge clk);

        // directed table: reset, single word, drain, mid-word reset
        for (int i = 0; i < 16; i++) begin
            if (vt[i].chk) begin
                chk($sformatf("v%0d_ready", i),
                    {31'd0, ready_and_o}, {31'd0, vt[i].e_rdy});
                chk($sformatf("v%0d_valid", i),
                    {31'd0, valid_o}, {31'd0, vt[i].e_vld});
                chk($sformatf("v%0d_count", i),
                    {28'd0, count_o}, {28'd0, vt[i].e_cnt});
                if (vt[i].e_vld)
                    chk($sformatf("v%0d_data", i), data_o, vt[i].e_dat);
            end
            reset_i = vt[i].rst;
            valid_i = vt[i].v;
            data_i  = vt[i].d;
            yumi_i  = vt[i].y;
            @(posedge clk);
            @(negedge clk);
        end

        // fill: three words back to back, no reads
        step(1, 0, '0, 0);
        for (int c = 0; c < 15; c++) begin
            d = {32'h0300 + c, 32'h0200 + c, 32'h0100 + c, 32'h0000 + c};
            step(0, 1, d, 0);
        end
        chk("fill_count", {28'd0, count_o}, 32'd0);
        chk("fill_stall", {31'd0, ready_and_o}, 32'd0);
        step(0, 0, '0, 1);
        chk("fill_yumi_count", {28'd0, count_o}, 32'd1);
        step(0, 0, '0, 0);
        chk("fill_refill_count", {28'd0, count_o}, 32'd0);

        // continuous stream with simultaneous write and read
        step(1, 0, '0, 0);
        nacc    = 0;
        started = 1'b0;
        first   = 1'b1;
        for (int c = 0; c < 40; c++) begin
            v = (nacc < 5);
            for (int i = 0; i < 4; i++)
                d[i*32 +: 32] = 32'h1000 + 32'(nacc * 4 + i);
            if (m_occ >= 3)
                started = 1'b1;
            y = started && (m_occ > 0);
            if (v && m_ser == 0)
                nacc++;
            step(0, v, d, y);
            if (y && first) begin
                chk("wrrd_count", {28'd0, count_o}, 32'd5);
                first = 1'b0;
            end
        end
        chk("wrrd_drained", {31'd0, valid_o}, 32'd0);

        // random traffic against the model
        step(1, 0, '0, 0);
        for (int c = 0; c < 10000; c++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            v = 1'($urandom_range(0, 1));
            y = (m_occ > 0) && ($urandom_range(0, 2) != 0);
            step(0, v, d, y);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
